// File: rtl/cdc_bus_tx_if.sv
// rtl/cdc_bus_tx_if.sv - handshake/bus bundle between upstream, cdc_bus_tx and the destination domain
//
// Signals:
//   in_data   upstream word to transfer
//   in_valid  upstream word is valid
//   in_ready  transmitter accepts a word this cycle
//   out_data  registered word presented to the destination domain
//   out_req   request toggle, one edge per new word
//   ack_async acknowledge toggle from the destination domain (asynchronous)
//   busy      transfer outstanding
//   err       sticky timeout flag
// Modports: slave = transmitter side, master = upstream/destination side.
interface cdc_bus_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_req;
    logic             ack_async;
    logic             busy;
    logic             err;

    modport slave (
        input  in_data,
        input  in_valid,
        input  ack_async,
        output in_ready,
        output out_data,
        output out_req,
        output busy,
        output err
    );

    modport master (
        output in_data,
        output in_valid,
        output ack_async,
        input  in_ready,
        input  out_data,
        input  out_req,
        input  busy,
        input  err
    );
endinterface

// File: rtl/cdc_bus_tx.sv
// rtl/cdc_bus_tx.sv - source side of a toggle req/ack handshake moving a word into another clock domain
//
// Ports:
//   clk  source-domain clock, rising edge
//   rst  asynchronous active-low reset
//   bus  cdc_bus_tx_if.slave: in_data/in_valid/in_ready upstream handshake,
//        out_data/out_req to the destination, ack_async back from it, busy, err
// Optional feature: define CDC_TX_TIMEOUT_EN to enable the WAIT-state timeout
// counter and the sticky err flag; otherwise err is tied low.
module cdc_bus_tx #(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    cdc_bus_tx_if.slave  bus
);

    // Reject configurations the synchronizer or counter cannot support.
    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("cdc_bus_tx: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES in 1..65535");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [WIDTH-1:0]       r_data;
    logic                   r_req;
    logic [SYNC_STAGES-1:0] r_ack_s;
    logic                   w_ack_sync;
    logic                   w_aligned;
    logic                   w_in_ready;
    logic                   w_busy;
    logic                   w_capture;

    // ack_async enters stage 0 only; nothing else looks at the raw input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack_s <= '0;
        end else begin
            r_ack_s <= {r_ack_s[SYNC_STAGES-2:0], bus.ack_async};
        end
    end

    assign w_ack_sync = r_ack_s[SYNC_STAGES-1];
    // Equal toggles mean the destination has consumed the last request.
    assign w_aligned  = (w_ack_sync == r_req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A spurious ack edge in IDLE simply blocks acceptance until
                // the toggles line up again.
                w_in_ready = w_aligned;
                if (bus.in_valid && w_aligned) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                if (w_aligned) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Data and request change together on capture only, so out_data is stable
    // for the whole time the destination may be sampling it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_req  <= 1'b0;
        end else if (w_capture) begin
            r_data <= bus.in_data;
            r_req  <= ~r_req;
        end
    end

    assign bus.out_data = r_data;
    assign bus.out_req  = r_req;
    assign bus.in_ready = w_in_ready;
    assign bus.busy     = w_busy;

`ifdef CDC_TX_TIMEOUT_EN
    localparam logic [15:0] L_TIMEOUT = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_cnt;
    logic        r_err;

    // r_cnt holds the number of WAIT cycles seen in the current transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT && r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (r_state == ST_WAIT && r_cnt == L_TIMEOUT) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_bus_tx.sv
// tb/tb_cdc_bus_tx.sv - directed self-checking bench for cdc_bus_tx
module tb_cdc_bus_tx;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int TO = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cdc_bus_tx_if #(.WIDTH(W)) bus ();

    cdc_bus_tx #(
        .WIDTH          (W),
        .SYNC_STAGES    (SS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] din;
        int           hold;
        logic [W-1:0] exp_dout;
    } vec_t;

    vec_t vecs[4];

    int   errors = 0;
    int   checks = 0;
    logic exp_req = 1'b0;
    logic exp_err_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{din: 8'hA5, hold: 3, exp_dout: 8'hA5};
        vecs[1] = '{din: 8'h01, hold: 0, exp_dout: 8'h01};
        vecs[2] = '{din: 8'h02, hold: 1, exp_dout: 8'h02};
        vecs[3] = '{din: 8'h03, hold: 5, exp_dout: 8'h03};
`ifdef CDC_TX_TIMEOUT_EN
        exp_err_stall = 1'b1;
`else
        exp_err_stall = 1'b0;
`endif

        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.ack_async = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_req",  bus.out_req,  0);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_err",      bus.err,      0);
        rst = 1'b1;
        tick();

        // Back-to-back transfers with in_valid held; ack echoed per request
        for (int i = 0; i < 4; i++) begin
            bus.in_data  = vecs[i].din;
            bus.in_valid = 1'b1;
            tick();
            exp_req = ~exp_req;
            chk("cap_out_data", bus.out_data, vecs[i].exp_dout);
            chk("cap_out_req",  bus.out_req,  exp_req);
            chk("cap_busy",     bus.busy,     1);
            chk("cap_in_ready", bus.in_ready, 0);
            bus.in_data = vecs[i].din ^ 8'hFF;
            repeat (vecs[i].hold) tick();
            chk("hold_out_data", bus.out_data, vecs[i].exp_dout);
            chk("hold_out_req",  bus.out_req,  exp_req);
            bus.ack_async = exp_req;
            repeat (SS) tick();
            chk("ack_early_in_ready", bus.in_ready, 0);
            chk("ack_early_out_data", bus.out_data, vecs[i].exp_dout);
            tick();
            chk("ack_in_ready", bus.in_ready, 1);
            chk("ack_busy",     bus.busy,     0);
            chk("ack_err",      bus.err,      0);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("idle_no_extra_req", bus.out_req, exp_req);

        // Stall: no ack for 100 cycles, new data offered and ignored
        bus.in_data  = 8'h5A;
        bus.in_valid = 1'b1;
        tick();
        exp_req = ~exp_req;
        bus.in_data = 8'hC3;
        repeat (100) tick();
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_out_data", bus.out_data, 8'h5A);
        chk("stall_out_req",  bus.out_req,  exp_req);
        chk("stall_busy",     bus.busy,     1);
        chk("stall_err",      bus.err,      exp_err_stall);
        bus.in_valid  = 1'b0;
        bus.ack_async = exp_req;
        repeat (SS + 1) tick();
        chk("stall_done_in_ready", bus.in_ready, 1);
        chk("stall_done_out_data", bus.out_data, 8'h5A);
        chk("stall_done_err",      bus.err,      exp_err_stall);

        // Spurious ack edge in IDLE
        bus.ack_async = ~exp_req;
        repeat (SS) tick();
        chk("spur_in_ready", bus.in_ready, 0);
        bus.in_data  = 8'h77;
        bus.in_valid = 1'b1;
        repeat (3) tick();
        chk("spur_no_req",  bus.out_req,  exp_req);
        chk("spur_no_cap",  bus.out_data, 8'h5A);
        chk("spur_busy",    bus.busy,     0);
        bus.in_valid  = 1'b0;
        bus.ack_async = exp_req;
        repeat (SS) tick();
        chk("spur_clear_in_ready", bus.in_ready, 1);
        chk("spur_clear_req",      bus.out_req,  exp_req);

        // Asynchronous reset in the middle of WAIT
        bus.in_data  = 8'hE7;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("pre_rst_busy", bus.busy, 1);
        #2;
        rst           = 1'b0;
        bus.ack_async = 1'b0;
        #1;
        chk("arst_out_req",  bus.out_req,  0);
        chk("arst_out_data", bus.out_data, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_busy",     bus.busy,     0);
        chk("arst_err",      bus.err,      0);
        exp_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Transfer after reset starts from a fresh toggle
        bus.in_data  = 8'h3C;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        exp_req = ~exp_req;
        chk("post_rst_out_data", bus.out_data, 8'h3C);
        chk("post_rst_out_req",  bus.out_req,  exp_req);
        bus.ack_async = exp_req;
        repeat (SS + 1) tick();
        chk("post_rst_in_ready", bus.in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
